// File: rtl/ram_port_sequencer.sv
// Burst command sequencer for one port of a synchronous-read RAM: accepts read/write
// bursts over valid/ready, drives one RAM beat at a time and returns read data.
module ram_port_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_HOLD
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [LEN_W-1:0]    r_beats_left;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_last;

  logic                w_last_beat;
  logic [ADDR_W-1:0]   w_next_addr;
  logic [LEN_W-1:0]    w_next_beats;

  assign w_last_beat  = (r_beats_left == '0);
  // Address arithmetic is modulo 2^ADDR_W; the carry out is simply dropped.
  assign w_next_addr  = r_cur_addr + ADDR_W'(1);
  assign w_next_beats = r_beats_left - LEN_W'(1);

  // NOTE: every register below is updated with non-blocking assignments so all state
  // advances together on the clock edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_beats_left <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_rd_last    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_cur_addr   <= cmd_addr;
            r_beats_left <= cmd_len;
            r_state      <= cmd_write ? S_WR : S_RD_ISSUE;
          end
        end
        S_WR: begin
          if (wr_valid) begin
            if (w_last_beat) begin
              r_state <= S_IDLE;
            end else begin
              r_cur_addr   <= w_next_addr;
              r_beats_left <= w_next_beats;
            end
          end
        end
        S_RD_ISSUE: begin
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // RAM output is valid exactly one cycle after the read strobe.
          r_rd_data  <= ram_q;
          r_rd_valid <= 1'b1;
          r_rd_last  <= w_last_beat;
          r_state    <= S_RD_HOLD;
        end
        S_RD_HOLD: begin
          if (rd_ready) begin
            r_rd_valid <= 1'b0;
            if (w_last_beat) begin
              r_state <= S_IDLE;
            end else begin
              r_cur_addr   <= w_next_addr;
              r_beats_left <= w_next_beats;
              r_state      <= S_RD_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset masks cmd_ready so no command is taken while the block is being cleared.
  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign wr_ready  = (r_state == S_WR);
  assign busy      = (r_state != S_IDLE);
  assign ram_we    = (r_state == S_WR) && wr_valid;
  assign ram_re    = (r_state == S_RD_ISSUE);
  assign ram_addr  = r_cur_addr;
  assign ram_wdata = wr_data;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_last   = r_rd_last;

endmodule

// File: tb/tb_ram_port_sequencer.sv
// Bench for ram_port_sequencer: a RAM model on the port plus a shadow memory that
// predicts every RAM beat and read response from the command stream alone.
module tb_ram_port_sequencer;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_q;
  logic          busy;

  logic [DW-1:0] mem     [64];
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] wbuf    [16];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  ram_port_sequencer #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_q(ram_q), .busy(busy)
  );

  // Synchronous-read RAM attached to the port.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_q <= mem[ram_addr];
  end

  // Advance one clock; strobes must never overlap in any cycle.
  task automatic step();
    n_cmp++;
    if (ram_we && ram_re) begin
      n_err++;
      $display("FAIL strobe_excl cyc=%0d: we=%0b re=%0b, required not both high", cyc, ram_we, ram_re);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] len,
                          input int stall_at, input int stall_n, input bit poke);
    logic [AW-1:0] ea;
    ea = a;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL wr_cmd_ready: got %0b, required 1", cmd_ready);
    end
    step();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_len = LW'($urandom);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          wr_valid = 1'b0; wr_data = DW'($urandom);
          if (poke) begin
            cmd_valid = 1'b1; cmd_addr = ~ea; cmd_write = 1'b0;
          end
          #1;
          n_cmp++;
          if (ram_we !== 1'b0 || wr_ready !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL wr_stall: we=%0b wr_ready=%0b cmd_ready=%0b busy=%0b, required 0 1 0 1",
                     ram_we, wr_ready, cmd_ready, busy);
          end
          step();
          cmd_valid = 1'b0;
        end
      end
      wr_valid = 1'b1; wr_data = wbuf[i];
      #1;
      n_cmp++;
      if (ram_we !== 1'b1 || ram_addr !== ea || ram_wdata !== wbuf[i] || ram_re !== 1'b0) begin
        n_err++;
        $display("FAIL wr_beat%0d: we=%0b addr=%h wdata=%h re=%0b, required 1 %h %h 0",
                 i, ram_we, ram_addr, ram_wdata, ram_re, ea, wbuf[i]);
      end
      ref_mem[ea] = wbuf[i];
      ea = ea + 1'b1;
      step();
    end
    wr_valid = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || ram_we !== 1'b0 || wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL wr_done: busy=%0b cmd_ready=%0b we=%0b wr_ready=%0b, required 0 1 0 0",
               busy, cmd_ready, ram_we, wr_ready);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] len,
                         input int stall_at, input int stall_n);
    logic [AW-1:0] ea;
    logic [DW-1:0] exp_d;
    logic          exp_l;
    ea = a;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL rd_cmd_ready: got %0b, required 1", cmd_ready);
    end
    step();
    cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_len = LW'($urandom);
    for (int i = 0; i <= int'(len); i++) begin
      wr_valid = 1'($urandom); rd_ready = 1'($urandom);
      #1;
      n_cmp++;
      if (ram_re !== 1'b1 || ram_addr !== ea || ram_we !== 1'b0 || rd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rd_issue%0d: re=%0b addr=%h we=%0b rd_valid=%0b, required 1 %h 0 0",
                 i, ram_re, ram_addr, ram_we, rd_valid, ea);
      end
      step();
      #1;
      n_cmp++;
      if (ram_re !== 1'b0 || rd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rd_wait%0d: re=%0b rd_valid=%0b, required 0 0", i, ram_re, rd_valid);
      end
      step();
      wr_valid = 1'b0;
      exp_d = ref_mem[ea];
      exp_l = (i == int'(len));
      for (int s = 0; s < ((i == stall_at) ? stall_n : 0); s++) begin
        rd_ready = 1'b0;
        #1;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== exp_d || rd_last !== exp_l || ram_re !== 1'b0) begin
          n_err++;
          $display("FAIL rd_stall%0d: valid=%0b data=%h last=%0b re=%0b, required 1 %h %0b 0",
                   i, rd_valid, rd_data, rd_last, ram_re, exp_d, exp_l);
        end
        step();
      end
      rd_ready = 1'b1;
      #1;
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d || rd_last !== exp_l) begin
        n_err++;
        $display("FAIL rd_beat%0d: valid=%0b data=%h last=%0b, required 1 %h %0b",
                 i, rd_valid, rd_data, rd_last, exp_d, exp_l);
      end
      step();
      ea = ea + 1'b1;
    end
    rd_ready = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_done: busy=%0b cmd_ready=%0b rd_valid=%0b, required 0 1 0",
               busy, cmd_ready, rd_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    step(); step();
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_cmd_ready_in_rst: got %0b, required 0", cmd_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0 ||
        rd_last !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0 || ram_addr !== '0 ||
        wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: rdy=%0b busy=%0b rv=%0b rd=%h rl=%0b we=%0b re=%0b addr=%h wrr=%0b, required 1 0 0 00 0 0 0 00 0",
               cmd_ready, busy, rd_valid, rd_data, rd_last, ram_we, ram_re, ram_addr, wr_ready);
    end
  endtask

  // Fill the whole RAM with four full-length bursts so every later read is predictable.
  task automatic test_fill();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) wbuf[i] = DW'($urandom);
      do_write(AW'(b * 16), 4'hF, -1, 0, 1'b0);
      step();
    end
  endtask

  task automatic test_single();
    wbuf[0] = 8'hA5;
    do_write(6'h05, 4'h0, -1, 0, 1'b0);
    step();
    do_read(6'h05, 4'h0, -1, 0);
    step();
  endtask

  task automatic test_write_wrap();
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_write(6'h3E, 4'h3, 2, 2, 1'b0);
    step();
    do_read(6'h3E, 4'h3, -1, 0);
    step();
  endtask

  task automatic test_read_stall();
    do_read(6'h10, 4'h3, 0, 3);
    step();
  endtask

  task automatic test_reset_mid_read();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h20; cmd_len = 4'h3;
    step();
    cmd_valid = 1'b0; rd_ready = 1'b1;
    step(); step(); step();
    step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_cmd_ready: got %0b, required 0", cmd_ready);
    end
    step();
    rst = 1'b0; rd_ready = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || ram_re !== 1'b0 || ram_we !== 1'b0 ||
        cmd_ready !== 1'b1 || rd_data !== '0) begin
      n_err++;
      $display("FAIL mid_rst_state: busy=%0b rv=%0b re=%0b we=%0b rdy=%0b rd=%h, required 0 0 0 0 1 00",
               busy, rd_valid, ram_re, ram_we, cmd_ready, rd_data);
    end
    for (int i = 0; i < 3; i++) wbuf[i] = DW'($urandom);
    do_write(6'h21, 4'h2, -1, 0, 1'b0);
    step();
  endtask

  task automatic test_cmd_while_busy();
    for (int i = 0; i < 5; i++) wbuf[i] = DW'($urandom);
    do_write(6'h30, 4'h4, 2, 3, 1'b1);
    step();
    do_read(6'h30, 4'h4, -1, 0);
  endtask

  task automatic test_random();
    int start;
    start = cyc;
    while (cyc < start + 1000) begin
      logic [AW-1:0] a;
      logic [LW-1:0] l;
      a = AW'($urandom);
      l = LW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) wbuf[i] = DW'($urandom);
        do_write(a, l, $urandom_range(0, 8), $urandom_range(0, 3), 1'($urandom));
      end else begin
        do_read(a, l, $urandom_range(0, 8), $urandom_range(0, 3));
      end
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_single();
    test_write_wrap();
    test_read_stall();
    test_reset_mid_read();
    test_cmd_while_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_sequencer.md
# ram_port_sequencer

Command sequencer that sits directly upstream of one port of the team's synchronous-read RAM block. It accepts burst read/write commands over a valid/ready handshake and drives the RAM port signals (`we`, `re`, `addr`, `data`) one beat at a time, auto-incrementing the address. It captures the registered read data (`q`) and returns it to the requester on a valid/ready response channel.

## Interface
- `DATA_W`, default 8: RAM word width.
- `ADDR_W`, default 6: RAM address width; addresses wrap modulo 2^ADDR_W.
- `LEN_W`, default 4: burst length field width; beats = `cmd_len` + 1, so 1..16 beats.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command; high only in IDLE.
- `cmd_write`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  ADDR_W  start address.
- `cmd_len`  in  LEN_W  beats minus one.
- `wr_valid`  in  1  write data beat present.
- `wr_ready`  out  1  write beat accepted; high only in WR.
- `wr_data`  in  DATA_W  write data beat.
- `rd_valid`  out  1  read response beat valid.
- `rd_ready`  in  1  consumer accepts the response beat.
- `rd_data`  out  DATA_W  read response data (registered).
- `rd_last`  out  1  marks the final beat of a read burst.
- `ram_we`  out  1  RAM write enable.
- `ram_re`  out  1  RAM read enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_q`  in  DATA_W  RAM read data, valid one cycle after `ram_re`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Internal state:
  - FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RD_HOLD.
  - `cur_addr` (ADDR_W bits).
  - `beats_left` (LEN_W bits).
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cur_addr`=`cmd_addr` and `beats_left`=`cmd_len`.
  - Go to WR if `cmd_write`=1, else to RD_ISSUE.
- WR:
  - `wr_ready`=1.
  - `ram_we` = `wr_valid`, `ram_addr` = `cur_addr`, `ram_wdata` = `wr_data` (combinational).
  - On each `wr_valid` beat:
    - If `beats_left`==0, go to IDLE.
    - Otherwise `cur_addr`+1 (wrapping) and `beats_left`-1.
  - `wr_valid`=0 stalls the burst with no RAM write.
- RD_ISSUE:
  - `ram_re`=1 and `ram_addr`=`cur_addr` for exactly one cycle.
  - Then go to RD_WAIT.
- RD_WAIT:
  - `rd_data` <= `ram_q`; `rd_valid` <= 1; `rd_last` <= (`beats_left`==0).
  - Go to RD_HOLD.
- RD_HOLD:
  - `rd_valid`, `rd_data` and `rd_last` are held stable until `rd_ready`.
  - On handshake, `rd_valid` <= 0.
  - If `beats_left`==0, go to IDLE.
  - Otherwise `cur_addr`+1, `beats_left`-1, and go to RD_ISSUE.
- `ram_we` and `ram_re` are never high in the same cycle.
- Outside WR, `ram_we`=0; outside RD_ISSUE, `ram_re`=0. `ram_addr` always equals `cur_addr`.
- Address wrap: `cur_addr` = 2^ADDR_W-1 increments to 0. No error is flagged.
- `cmd_*` inputs are ignored outside IDLE. `wr_*` inputs are ignored outside WR.

## Timing
- Reset values:
  - FSM in IDLE; `cur_addr`=0; `beats_left`=0.
  - `rd_valid`=0, `rd_data`=0, `rd_last`=0, `busy`=0.
  - `ram_we`=0, `ram_re`=0, `ram_addr`=0, `wr_ready`=0.
  - `cmd_ready`=1 in the first cycle after `rst` deasserts. While `rst` is high, `cmd_ready`=0.
- `rst` mid-burst:
  - Takes effect on the next edge and returns the block to IDLE.
  - Any in-flight RAM read data is discarded.
  - Any pending response is dropped (`rd_valid` goes to 0).
  - No RAM strobe is asserted in the cycle after the reset edge.
- Command accept takes 1 cycle. The first RAM strobe occurs in the cycle after the `cmd_valid`&`cmd_ready` handshake.
- Write throughput: 1 beat/cycle when `wr_valid` is held high. A burst of N beats occupies exactly N cycles in WR.
- Read latency: `ram_re` at cycle t, `rd_valid` at cycle t+2.
- Read throughput: with `rd_ready` tied high, 3 cycles per beat (ISSUE, WAIT, HOLD).
- Back-to-back commands: after the last beat the block is in IDLE for one cycle, so there is a minimum 1-cycle gap between bursts.

## Test plan
- Single write, then single read:
  - Write: `cmd_write`=1, `addr`=0x05, `len`=0, `wr_data`=0xA5 -> one cycle with `ram_we`=1, `ram_addr`=0x05, `ram_wdata`=0xA5.
  - Read: `addr`=0x05 (RAM model returns 0xA5) -> `rd_data`=0xA5, `rd_last`=1, 2 cycles after `ram_re`.
- Write burst with wrap: `addr`=0x3E, `len`=3, data 0x11,0x22,0x33,0x44 with `wr_valid` low for 2 cycles after beat 2 -> `ram_addr` sequence 0x3E,0x3F,0x00,0x01, no `ram_we` during the stall, then IDLE.
- Read burst 4 beats from 0x10 with `rd_ready` low for 3 cycles on beat 1:
  - `rd_data`/`rd_last` stay stable while stalled.
  - No further `ram_re` is issued until the handshake.
  - `rd_last`=1 only on beat 4.
- Reset mid-read: assert `rst` in RD_WAIT of beat 2 of a 4-beat read -> next cycle IDLE, `rd_valid`=0, `busy`=0, `ram_re`=0; a new write command is accepted normally afterwards.
- Command while busy: pulse `cmd_valid` during a write burst -> `cmd_ready` stays 0, the command is not latched, and the burst addresses are unchanged.
- Mutual exclusion check: random command mix, 1000 cycles -> assertion that `ram_we`&`ram_re` is never high and `ram_addr`==`cur_addr` every cycle.
